// File: rtl/puf_verifier.sv
// ----------------------------------------------------------------------------
// puf_verifier
//   Challenge-issuing side of an RO PUF challenge/response link. Holds an
//   enrolled table of NUM_PAIRS (challenge, expected response) pairs, replays
//   them to the PUF on START, and reports a pass/fail verdict based on how many
//   responses fall within HD_THRESH masked Hamming distance of the enrolment.
//
// Ports
//   CLK          in   1     system clock, all logic on posedge
//   RESET        in   1     synchronous, active-high
//   START        in   1     begin a run (accepted only in IDLE)
//   WR_EN        in   1     table write strobe (accepted only in IDLE)
//   WR_ADDR      in   AW    table index
//   WR_CHAL      in   7     challenge bits for the entry
//   WR_RESP      in   8     expected response for the entry
//   CHALLENGE    out  8     to PUF: [6:0] table challenge, [7] parity pad
//   RESPONSE     in   8     from PUF
//   PUF_DONE     in   1     from PUF: high = idle / result valid
//   BUSY         out  1     run in progress
//   DONE         out  1     verdict valid, held until next accepted START
//   PASS         out  1     enough matches and no timeout (valid with DONE)
//   MATCH_COUNT  out  AW+1  matching pairs in the current/last run
//   TIMEOUT      out  1     last run aborted waiting for PUF_DONE
//   HD_TOTAL     out  AW+5  (PUF_VERIFY_STATS_EN only) summed hd of the run
//
// Build option
//   PUF_VERIFY_STATS_EN : adds HD_TOTAL and its accumulator.
// ----------------------------------------------------------------------------
module puf_verifier #(
    parameter int unsigned NUM_PAIRS      = 8,
    parameter int unsigned HD_THRESH      = 1,
    parameter int unsigned MIN_MATCH      = 6,
    parameter logic [7:0]  RESP_MASK      = 8'hFE,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2**21,
    localparam int unsigned AW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [6:0]    WR_CHAL,
    input  logic [7:0]    WR_RESP,
    output logic [7:0]    CHALLENGE,
    input  logic [7:0]    RESPONSE,
    input  logic          PUF_DONE,
    output logic          BUSY,
    output logic          DONE,
    output logic          PASS,
    output logic [AW:0]   MATCH_COUNT,
    output logic          TIMEOUT
`ifdef PUF_VERIFY_STATS_EN
    ,
    output logic [AW+4:0] HD_TOTAL
`endif
);

    localparam int unsigned TMAX  = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW    = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned DEPTH = 2**AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_COMPARE,
        S_FINISH
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [6:0]     r_tbl_chal [DEPTH];
    logic [7:0]     r_tbl_resp [DEPTH];

    logic [AW-1:0]  r_idx;
    logic [TW-1:0]  r_timer;
    logic [7:0]     r_challenge;
    logic           r_busy;
    logic           r_done;
    logic           r_pass;
    logic [AW:0]    r_match_count;
    logic           r_timeout;

    logic           w_wr_ok;
    logic [6:0]     w_cur_chal;
    logic           w_pad;
    logic [7:0]     w_diff;
    logic [3:0]     w_hd;
    logic           w_match;
    logic           w_settle_last;
    logic           w_timeout_last;
    logic           w_idx_last;

    assign w_wr_ok        = !RESET && (r_state == S_IDLE) && WR_EN && (32'(WR_ADDR) < NUM_PAIRS);
    assign w_cur_chal     = r_tbl_chal[r_idx];
    // Pad bit forces the parity of the new challenge to differ from the one
    // currently driven, so even a repeated challenge retriggers the PUF.
    assign w_pad          = ~(^r_challenge) ^ (^w_cur_chal);
    assign w_diff         = (RESPONSE ^ r_tbl_resp[r_idx]) & RESP_MASK;
    assign w_match        = (32'(w_hd) <= HD_THRESH);
    assign w_settle_last  = (r_timer == TW'(SETTLE_CYCLES - 1));
    assign w_timeout_last = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_idx_last     = (r_idx == AW'(NUM_PAIRS - 1));

    always_comb begin
        w_hd = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_hd = w_hd + {3'b000, w_diff[i]};
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (START) w_state_next = S_ISSUE;
            S_ISSUE:   w_state_next = S_SETTLE;
            S_SETTLE:  if (w_settle_last) w_state_next = S_WAIT;
            S_WAIT: begin
                if (PUF_DONE) begin
                    w_state_next = S_COMPARE;
                end else if (w_timeout_last) begin
                    w_state_next = S_FINISH;
                end
            end
            S_COMPARE: w_state_next = w_idx_last ? S_FINISH : S_ISSUE;
            S_FINISH:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Enrolment table: deliberately not reset
    always_ff @(posedge CLK) begin
        if (w_wr_ok) begin
            r_tbl_chal[WR_ADDR] <= WR_CHAL;
            r_tbl_resp[WR_ADDR] <= WR_RESP;
        end
    end

`ifdef PUF_VERIFY_STATS_EN
    logic [AW+4:0] r_hd_total;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hd_total <= '0;
        end else if (r_state == S_IDLE && START) begin
            r_hd_total <= '0;
        end else if (r_state == S_COMPARE) begin
            r_hd_total <= r_hd_total + {{(AW+1){1'b0}}, w_hd};
        end
    end

    assign HD_TOTAL = r_hd_total;
`endif

    // Run datapath
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_idx         <= '0;
            r_timer       <= '0;
            r_challenge   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_match_count <= '0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_match_count <= '0;
                        r_idx         <= '0;
                        r_busy        <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_challenge <= {w_pad, w_cur_chal};
                    r_timer     <= '0;
                end
                // Timer is shared: it counts settle cycles, then restarts
                // from zero for the PUF_DONE wait.
                S_SETTLE: begin
                    if (w_settle_last) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!PUF_DONE) begin
                        if (w_timeout_last) begin
                            r_timeout <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                S_COMPARE: begin
                    if (w_match) begin
                        r_match_count <= r_match_count + 1'b1;
                    end
                    if (!w_idx_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_pass <= (32'(r_match_count) >= MIN_MATCH) && !r_timeout;
                end
                default: ;
            endcase
        end
    end

    assign CHALLENGE   = r_challenge;
    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign PASS        = r_pass;
    assign MATCH_COUNT = r_match_count;
    assign TIMEOUT     = r_timeout;

endmodule

// File: tb/tb_puf_verifier.sv
module tb_puf_verifier;

    localparam int NP  = 8;
    localparam int AW  = 3;
    localparam int MIN = 6;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        WR_EN = 1'b0;
    logic [2:0]  WR_ADDR = '0;
    logic [6:0]  WR_CHAL = '0;
    logic [7:0]  WR_RESP = '0;
    logic [7:0]  RESPONSE = '0;
    logic        PUF_DONE = 1'b1;

    logic [7:0]  a_CHALLENGE, b_CHALLENGE;
    logic        a_BUSY, a_DONE, a_PASS, a_TIMEOUT;
    logic        b_BUSY, b_DONE, b_PASS, b_TIMEOUT;
    logic [3:0]  a_MC, b_MC;
`ifdef PUF_VERIFY_STATS_EN
    logic [7:0]  a_HD, b_HD;
`endif

    // Threshold 1 and threshold 2 instances share all stimulus.
    puf_verifier #(.HD_THRESH(1), .TIMEOUT_CYCLES(100)) dut_a (
        .CLK(CLK), .RESET(RESET), .START(START), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_CHAL(WR_CHAL), .WR_RESP(WR_RESP), .CHALLENGE(a_CHALLENGE), .RESPONSE(RESPONSE),
        .PUF_DONE(PUF_DONE), .BUSY(a_BUSY), .DONE(a_DONE), .PASS(a_PASS),
        .MATCH_COUNT(a_MC), .TIMEOUT(a_TIMEOUT)
`ifdef PUF_VERIFY_STATS_EN
        , .HD_TOTAL(a_HD)
`endif
    );

    puf_verifier #(.HD_THRESH(2), .TIMEOUT_CYCLES(100)) dut_b (
        .CLK(CLK), .RESET(RESET), .START(START), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_CHAL(WR_CHAL), .WR_RESP(WR_RESP), .CHALLENGE(b_CHALLENGE), .RESPONSE(RESPONSE),
        .PUF_DONE(PUF_DONE), .BUSY(b_BUSY), .DONE(b_DONE), .PASS(b_PASS),
        .MATCH_COUNT(b_MC), .TIMEOUT(b_TIMEOUT)
`ifdef PUF_VERIFY_STATS_EN
        , .HD_TOTAL(b_HD)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Bench-side view of the enrolment table and of the per-run PUF answers
    logic [6:0] tbl_chal [NP];
    logic [7:0] tbl_resp [NP];
    logic [7:0] resp_plan [NP];
    logic [7:0] model_chal = '0;
    logic       puf_stuck = 1'b0;
    int         run_gen = 0;

    // PUF behavioural model: a parity change on CHALLENGE starts a measurement
    int         gen_seen = 0;
    int         seen_n = 0;
    int         cur_slot = 0;
    int         puf_cnt = 0;
    logic       last_par = 1'b0;
    logic [7:0] seen_chal [NP];

    always @(negedge CLK) begin
        if (run_gen != gen_seen) begin
            gen_seen = run_gen;
            seen_n   = 0;
        end
        if (RESET) begin
            last_par = 1'b0;
            PUF_DONE = 1'b1;
        end else if ((^a_CHALLENGE) != last_par) begin
            last_par = ^a_CHALLENGE;
            if (seen_n < NP) seen_chal[seen_n] = a_CHALLENGE;
            cur_slot = seen_n;
            seen_n++;
            PUF_DONE = 1'b0;
            RESPONSE = 8'($urandom);
            puf_cnt  = $urandom_range(12, 1);
        end else if (!PUF_DONE && !puf_stuck) begin
            if (puf_cnt <= 1) begin
                PUF_DONE = 1'b1;
                RESPONSE = resp_plan[cur_slot % NP];
            end else begin
                puf_cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] next_chal(input logic [7:0] prev, input logic [6:0] c);
        logic p;
        p = (($countones(c) % 2) == ($countones(prev) % 2));
        return {p, c};
    endfunction

    function automatic int hd_of(input int k);
        return $countones((resp_plan[k] ^ tbl_resp[k]) & 8'hFE);
    endfunction

    function automatic int exp_matches(input int thresh);
        int n = 0;
        for (int k = 0; k < NP; k++) if (hd_of(k) <= thresh) n++;
        return n;
    endfunction

    task automatic write_entry(input int addr, input logic [6:0] c, input logic [7:0] r);
        WR_EN = 1'b1; WR_ADDR = 3'(addr); WR_CHAL = c; WR_RESP = r;
        tick();
        WR_EN = 1'b0;
        tbl_chal[addr] = c;
        tbl_resp[addr] = r;
    endtask

    task automatic start_run(input bit with_wr, input int addr, input logic [6:0] c, input logic [7:0] r);
        run_gen++;
        START = 1'b1;
        if (with_wr) begin
            WR_EN = 1'b1; WR_ADDR = 3'(addr); WR_CHAL = c; WR_RESP = r;
        end
        tick();
        START = 1'b0;
        WR_EN = 1'b0;
        chk("start_busy", a_BUSY, 1);
        chk("start_done_clear", a_DONE, 0);
        chk("start_mc_clear", a_MC, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (a_DONE !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk("done_within_bound", a_DONE, 1);
    endtask

    task automatic check_run(input string tag);
        int m1, m2;
        wait_done();
        m1 = exp_matches(1);
        m2 = exp_matches(2);
        chk({tag, "_busy"}, a_BUSY, 0);
        chk({tag, "_timeout"}, a_TIMEOUT, 0);
        chk({tag, "_mc_t1"}, a_MC, m1);
        chk({tag, "_pass_t1"}, a_PASS, (m1 >= MIN) ? 1 : 0);
        chk({tag, "_mc_t2"}, b_MC, m2);
        chk({tag, "_pass_t2"}, b_PASS, (m2 >= MIN) ? 1 : 0);
        chk({tag, "_issues"}, seen_n, NP);
        for (int k = 0; k < NP; k++) begin
            model_chal = next_chal(model_chal, tbl_chal[k]);
            chk($sformatf("%s_chal%0d", tag, k), seen_chal[k], model_chal);
        end
        chk({tag, "_chal_hold"}, a_CHALLENGE, model_chal);
`ifdef PUF_VERIFY_STATS_EN
        begin
            int s = 0;
            for (int k = 0; k < NP; k++) s += hd_of(k);
            chk({tag, "_hd_total"}, a_HD, s);
        end
`endif
    endtask

    task automatic plan_all_match();
        for (int k = 0; k < NP; k++)
            resp_plan[k] = {tbl_resp[k][7:1], 1'($urandom)};
    endtask

    task automatic plan_random();
        for (int k = 0; k < NP; k++)
            resp_plan[k] = tbl_resp[k] ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_challenge"}, a_CHALLENGE, 0);
        chk({tag, "_busy"}, a_BUSY, 0);
        chk({tag, "_done"}, a_DONE, 0);
        chk({tag, "_pass"}, a_PASS, 0);
        chk({tag, "_mc"}, a_MC, 0);
        chk({tag, "_timeout"}, a_TIMEOUT, 0);
    endtask

    initial begin
        logic [7:0] m;
        logic [6:0] nc;
        logic [7:0] nr;

        // Reset
        RESET = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        RESET = 1'b0;
        tick();

        // Enrolment: entries 0 and 1 share a challenge
        write_entry(0, 7'h03, 8'($urandom));
        write_entry(1, 7'h03, 8'($urandom));
        for (int k = 2; k < NP; k++) write_entry(k, 7'($urandom), 8'($urandom));

        // All match, with a START and a table write attempted mid-run
        plan_all_match();
        start_run(0, 0, '0, '0);
        repeat (3) tick();
        START = 1'b1; WR_EN = 1'b1; WR_ADDR = 3'd2;
        WR_CHAL = ~tbl_chal[2]; WR_RESP = ~tbl_resp[2];
        tick();
        START = 1'b0; WR_EN = 1'b0;
        check_run("allmatch");
        chk("allmatch_first_chal", seen_chal[0], 8'h83);
        chk("allmatch_second_chal", seen_chal[1], 8'h03);
        chk("allmatch_done_held", a_DONE, 1);
        tick();
        chk("allmatch_done_still_held", a_DONE, 1);

        // Threshold edge: 3 entries at hd 2, 5 at hd 1
        m = '0;
        while ($countones(m) < 3) m[$urandom_range(7, 0)] = 1'b1;
        for (int k = 0; k < NP; k++)
            resp_plan[k] = tbl_resp[k] ^ (m[k] ? 8'h06 : 8'h02) ^ {7'b0, 1'($urandom)};
        start_run(0, 0, '0, '0);
        check_run("thresh");
        chk("thresh_mc_t1_is5", a_MC, 5);
        chk("thresh_mc_t2_is8", b_MC, 8);

        // Entry 2 must be untouched by the write issued while busy
        plan_all_match();
        start_run(0, 0, '0, '0);
        check_run("guard");

        // Random runs; some write an entry in the same cycle as START
        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 0) begin
                nc = 7'($urandom);
                nr = 8'($urandom);
                tbl_chal[r] = nc;
                tbl_resp[r] = nr;
                plan_random();
                start_run(1, r, nc, nr);
            end else begin
                plan_random();
                start_run(0, 0, '0, '0);
            end
            check_run($sformatf("rand%0d", r));
        end

        // Timeout: PUF never completes after the first issue
        puf_stuck = 1'b1;
        start_run(0, 0, '0, '0);
        repeat (104) tick();
        chk("to_not_yet_timeout", a_TIMEOUT, 0);
        chk("to_not_yet_done", a_DONE, 0);
        tick();
        chk("to_timeout_flag", a_TIMEOUT, 1);
        chk("to_done_before_finish", a_DONE, 0);
        tick();
        chk("to_done", a_DONE, 1);
        chk("to_pass", a_PASS, 0);
        chk("to_mc", a_MC, 0);
        chk("to_busy", a_BUSY, 0);
        chk("to_issues", seen_n, 1);
        model_chal = next_chal(model_chal, tbl_chal[0]);
        chk("to_chal", seen_chal[0], model_chal);
        puf_stuck = 1'b0;
        repeat (20) tick();

        // Reset while waiting on the PUF
        puf_stuck = 1'b1;
        start_run(0, 0, '0, '0);
        repeat (10) tick();
        chk("midreset_busy_before", a_BUSY, 1);
        RESET = 1'b1;
        tick();
        check_reset_outputs("midreset");
        RESET = 1'b0;
        model_chal = '0;
        puf_stuck = 1'b0;
        repeat (3) tick();

        plan_all_match();
        start_run(0, 0, '0, '0);
        check_run("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
